// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Requester-side request/response handshake bundle for one
//                port of mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter sharing one single-port word memory
//                between a load/store port (m0) and a fetch port (m1).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  wire                clk,
  input  wire                rst,
  mem_arbiter_if.slave       m0,
  mem_arbiter_if.slave       m1,
  output logic [ADDR_W-1:0]  mem_addrs,
  output logic               mem_read,
  output logic               mem_write,
  output logic [DATA_W-1:0]  write_data,
  input  wire  [DATA_W-1:0]  read_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              rsp_valid0_q, rsp_valid0_d;
  logic              rsp_valid1_q, rsp_valid1_d;

  logic              w_any;
  logic              w_gnt;
  logic              w_accept;
  logic              w_rsp_ready;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    w_any = m0.req_valid | m1.req_valid;
    if (m0.req_valid && m1.req_valid) begin
      w_gnt = ~last_grant_q;
    end else begin
      w_gnt = m1.req_valid;
    end
    w_accept    = (state_q == S_IDLE) && w_any;
    w_rsp_ready = id_q ? m1.rsp_ready : m0.rsp_ready;
  end

  assign m0.req_ready = w_accept && !w_gnt;
  assign m1.req_ready = w_accept &&  w_gnt;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    rsp_valid0_d = rsp_valid0_q;
    rsp_valid1_d = rsp_valid1_q;

    unique case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          id_d         = w_gnt;
          last_grant_d = w_gnt;
          we_d         = w_gnt ? m1.req_we    : m0.req_we;
          addr_d       = w_gnt ? m1.req_addr  : m0.req_addr;
          wdata_d      = w_gnt ? m1.req_wdata : m0.req_wdata;
          mem_read_d   = !we_d;
          mem_write_d  = we_d;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Capture the combinational read path here so the requester sees a flop.
        rdata_d      = we_q ? '0 : read_data;
        rsp_valid0_d = !id_q;
        rsp_valid1_d = id_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (w_rsp_ready) begin
          rsp_valid0_d = 1'b0;
          rsp_valid1_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        rsp_valid0_d = 1'b0;
        rsp_valid1_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
    end
  end

  assign m0.rsp_valid = rsp_valid0_q;
  assign m1.rsp_valid = rsp_valid1_q;
  assign m0.rsp_rdata = rsp_valid0_q ? rdata_q : '0;
  assign m1.rsp_rdata = rsp_valid1_q ? rdata_q : '0;

  assign mem_addrs  = addr_q;
  assign write_data = wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

endmodule
`default_nettype wire
